mont_precomp: RTL and testbench
===============================

// Module: mont_precomp
// PURPOSE
//   Upstream setup stage for mod_exp. Given modulus N and bit length len (R = 2^len), it computes
//   the Montgomery constants R mod N and R^2 mod N. mod_exp uses them to move operands into
//   and out of Montgomery form.
//   Method: bit-serial doubling with conditional subtraction, one modular doubling per clock.
//   Results are registered and held until the next accepted start.
// PARAMETERS
//   WIDTH  32  operand/modulus width in bits
//   LEN_W  8   width of len input
// PORTS
//   clk        in   1      clock, all logic on rising edge
//   rstn       in   1      synchronous active-low reset
//   pc_start   in   1      start request, sampled only in IDLE
//   len        in   LEN_W  modulus bit length; R = 2^len
//   modulus    in   WIDTH  modulus N
//   pc_r_mod   out  WIDTH  R mod N
//   pc_r2_mod  out  WIDTH  R^2 mod N
//   pc_busy    out  1      high from accept through DONE
//   pc_end     out  1      one-cycle completion pulse (success or error)
//   pc_err     out  1      invalid-input flag, valid with pc_end, held until next accept
// BEHAVIOUR
//   Reset (rstn=0 at a clk edge):
//     - state=IDLE; pc_r_mod, pc_r2_mod, pc_busy, pc_end, pc_err all 0.
//     - Applies mid-operation too: the run is aborted with no pc_end.
//   FSM IDLE -> CHECK -> RUN -> DONE -> IDLE.
//   IDLE:
//     - pc_start=1 latches len and modulus into internal registers.
//     - Clears pc_r_mod, pc_r2_mod and pc_err; goes to CHECK.
//     - Inputs may change after the accept cycle.
//   CHECK (1 cycle): error if any of the following holds:
//     - N[0]==0 (even modulus)
//     - N<3
//     - len==0 or len>WIDTH
//     - N >= 2^len (compare at WIDTH+1 bits so len==WIDTH is legal)
//     On error: set err, go to DONE. Otherwise acc=1, cnt=0, go to RUN.
//   RUN, each cycle:
//     - t = {acc,1'b0} (WIDTH+1 bits); acc = (t>=N) ? t-N : t.
//     - Invariant acc<N holds, so one subtraction suffices.
//     - When cnt==len-1: pc_r_mod <= new acc.
//     - When cnt==2*len-1: pc_r2_mod <= new acc, go to DONE.
//     - Otherwise cnt++. cnt is LEN_W+1 bits.
//   DONE (1 cycle): pc_end=1; pc_err=err; next state IDLE.
//   pc_busy=1 in CHECK, RUN and DONE. pc_start is ignored while busy.
//   Latency (acceptance edge = cycle 0):
//     - valid input: pc_end high during cycle 2*len+2
//     - error: pc_end high during cycle 2
//   pc_start may be asserted in the cycle after DONE, and a new run is accepted then.
//   On error, pc_r_mod and pc_r2_mod stay 0.
// TESTING
//   1. len=4, N=13, pulse pc_start -> pc_end at cycle 10, pc_r_mod=3, pc_r2_mod=9, pc_err=0.
//   2. len=27, N=128255609 -> pc_end at cycle 56, pc_r_mod=5962119, pc_r2_mod=51402157;
//      feeding these to mod_exp yields the same mm_2_out as the software model.
//   3. Error cases, each -> pc_end at cycle 2, pc_err=1, results 0:
//      N=128 len=8; N=200 len=7; len=0; len=33.
//   4. pc_start held high for a full run with len=4, N=13 -> exactly one pc_end per run;
//      next run accepted the cycle after DONE; results identical.
//   5. rstn=0 for one cycle at cycle 5 of a len=27 run -> all outputs 0, no pc_end,
//      a new start completes correctly.
//   6. len=32, N=0xFFFFFFFB -> pc_r_mod=5, pc_r2_mod=25, no overflow in the t>=N compare.

Source files
------------

// File: rtl/mont_precomp.sv
// ----------------------------------------------------------------------------
// mont_precomp
//   Setup stage for mod_exp. For an odd modulus N and bit length len
//   (R = 2^len) it produces the Montgomery constants R mod N and R^2 mod N.
//   Starting from acc = 1, it performs one modular doubling per clock.
//   After len doublings acc holds R mod N. After 2*len doublings acc holds
//   R^2 mod N. Results are registered and held until the next accepted start.
//
// Ports
//   clk        in   1      clock, rising edge
//   rstn       in   1      synchronous active-low reset
//   pc_start   in   1      start request, only looked at while idle
//   len        in   LEN_W  modulus bit length, R = 2^len
//   modulus    in   WIDTH  modulus N
//   pc_r_mod   out  WIDTH  R mod N
//   pc_r2_mod  out  WIDTH  R^2 mod N
//   pc_busy    out  1      high from accept through DONE
//   pc_end     out  1      one-cycle completion pulse (success or error)
//   pc_err     out  1      invalid-input flag, valid with pc_end, held until next accept
// ----------------------------------------------------------------------------
module mont_precomp #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pc_start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] pc_r_mod,
  output logic [WIDTH-1:0] pc_r2_mod,
  output logic             pc_busy,
  output logic             pc_end,
  output logic             pc_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [WIDTH-1:0]   r_mod;
  logic [WIDTH-1:0]   r_acc;
  logic [LEN_W:0]     r_cnt;
  logic               r_err;
  logic [WIDTH-1:0]   r_r_mod;
  logic [WIDTH-1:0]   r_r2_mod;
  logic               r_busy;
  logic               r_end;
  logic               r_pc_err;

  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH:0]     w_pow;
  logic               w_in_err;
  logic [LEN_W:0]     w_last_r;
  logic [LEN_W:0]     w_last_r2;

  // 2*acc mod N. The doubled value is kept at WIDTH+1 bits so that the
  // compare stays correct when N fills all WIDTH bits. Because acc < N,
  // a single conditional subtraction is enough.
  function automatic logic [WIDTH-1:0] mod_double(input logic [WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] n);
    logic [WIDTH:0] t;
    logic [WIDTH:0] d;
    t = {acc, 1'b0};
    if (t >= {1'b0, n}) begin
      d = t - {1'b0, n};
    end else begin
      d = t;
    end
    return d[WIDTH-1:0];
  endfunction

  // Next accumulator value, input validity check and counter end points.
  always_comb begin
    w_acc_nxt = mod_double(r_acc, r_mod);
    // 2^len at WIDTH+1 bits so that len == WIDTH is still representable.
    // An out-of-range len is flagged separately, so a shifted-out result
    // does not matter.
    w_pow     = {{WIDTH{1'b0}}, 1'b1} << r_len;
    w_in_err  = (r_mod[0] == 1'b0)
              | (r_mod < {{(WIDTH-2){1'b0}}, 2'b11})
              | (r_len == {LEN_W{1'b0}})
              | (r_len > LEN_MAX)
              | ({1'b0, r_mod} >= w_pow);
    w_last_r  = {1'b0, r_len} - {{LEN_W{1'b0}}, 1'b1};
    w_last_r2 = {r_len, 1'b0} - {{LEN_W{1'b0}}, 1'b1};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_len    <= {LEN_W{1'b0}};
      r_mod    <= {WIDTH{1'b0}};
      r_acc    <= {WIDTH{1'b0}};
      r_cnt    <= {(LEN_W+1){1'b0}};
      r_err    <= 1'b0;
      r_r_mod  <= {WIDTH{1'b0}};
      r_r2_mod <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_end    <= 1'b0;
      r_pc_err <= 1'b0;
    end else begin
      r_end <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pc_start) begin
            r_len    <= len;
            r_mod    <= modulus;
            r_r_mod  <= {WIDTH{1'b0}};
            r_r2_mod <= {WIDTH{1'b0}};
            r_pc_err <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_in_err) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_err   <= 1'b0;
            r_acc   <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_cnt   <= {(LEN_W+1){1'b0}};
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          // After len doublings acc holds R mod N.
          if (r_cnt == w_last_r) begin
            r_r_mod <= w_acc_nxt;
          end
          // After 2*len doublings acc holds R^2 mod N.
          if (r_cnt == w_last_r2) begin
            r_r2_mod <= w_acc_nxt;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + {{LEN_W{1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          r_end    <= 1'b1;
          r_pc_err <= r_err;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc_r_mod  = r_r_mod;
  assign pc_r2_mod = r_r2_mod;
  assign pc_busy   = r_busy;
  assign pc_end    = r_end;
  assign pc_err    = r_pc_err;

endmodule

// File: tb/tb_mont_precomp.sv
module tb_mont_precomp;

  logic        clk;
  logic        rstn;
  logic        pc_start;
  logic [7:0]  len;
  logic [31:0] modulus;
  logic [31:0] pc_r_mod;
  logic [31:0] pc_r2_mod;
  logic        pc_busy;
  logic        pc_end;
  logic        pc_err;

  int n_checks = 0;
  int n_fail   = 0;

  mont_precomp #(.WIDTH(32), .LEN_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pc_start  (pc_start),
    .len       (len),
    .modulus   (modulus),
    .pc_r_mod  (pc_r_mod),
    .pc_r2_mod (pc_r2_mod),
    .pc_busy   (pc_busy),
    .pc_end    (pc_end),
    .pc_err    (pc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start pulse, then scramble the inputs. Report the cycle in which
  // pc_end rises (acceptance edge = cycle 0) and the outputs seen in that cycle.
  // ec = -1 means that no pc_end arrived within the budget.
  task automatic do_run(input logic [7:0] l, input logic [31:0] n, output int ec,
                        output logic [31:0] r, output logic [31:0] r2,
                        output logic e, output logic b0);
    @(negedge clk);
    len = l; modulus = n; pc_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pc_start = 1'b0; len = 8'hA5; modulus = 32'h0000_0000;
    b0 = pc_busy;
    ec = -1; r = 32'h0; r2 = 32'h0; e = 1'b0;
    for (int c = 1; c <= 200 && ec < 0; c++) begin
      @(posedge clk); #1;
      if (pc_end === 1'b1) begin
        ec = c; r = pc_r_mod; r2 = pc_r2_mod; e = pc_err;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; pc_start = 1'b0; len = 8'd0; modulus = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({pc_r_mod, pc_r2_mod, pc_busy, pc_end, pc_err} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got r=%h r2=%h busy=%b end=%b err=%b, expected all 0",
               pc_r_mod, pc_r2_mod, pc_busy, pc_end, pc_err);
    end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_basic();
    int ec; logic [31:0] r, r2; logic e, b0;
    do_run(8'd4, 32'd13, ec, r, r2, e, b0);
    n_checks++;
    if (b0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", b0); end
    n_checks++;
    if (ec !== 10) begin n_fail++; $display("FAIL basic_latency: got %0d expected 10", ec); end
    n_checks++;
    if (r !== 32'd3 || r2 !== 32'd9 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got r=%0d r2=%0d err=%b expected 3 9 0", r, r2, e);
    end
    // The pulse lasts one cycle and the results stay held afterwards.
    @(posedge clk); #1;
    n_checks++;
    if (pc_end !== 1'b0 || pc_busy !== 1'b0 || pc_r_mod !== 32'd3 || pc_r2_mod !== 32'd9) begin
      n_fail++;
      $display("FAIL basic_hold: got end=%b busy=%b r=%0d r2=%0d expected 0 0 3 9",
               pc_end, pc_busy, pc_r_mod, pc_r2_mod);
    end
  endtask

  task automatic test_len27();
    int ec; logic [31:0] r, r2; logic e, b0;
    do_run(8'd27, 32'd128255609, ec, r, r2, e, b0);
    n_checks++;
    if (ec !== 56) begin n_fail++; $display("FAIL len27_latency: got %0d expected 56", ec); end
    n_checks++;
    if (r !== 32'd5962119 || r2 !== 32'd51402157 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL len27_result: got r=%0d r2=%0d err=%b expected 5962119 51402157 0", r, r2, e);
    end
  endtask

  task automatic test_errors();
    logic [7:0]  l_tab [6];
    logic [31:0] n_tab [6];
    int ec; logic [31:0] r, r2; logic e, b0;
    l_tab = '{8'd8, 8'd7, 8'd0, 8'd33, 8'd4, 8'd4};
    n_tab = '{32'd128, 32'd200, 32'd13, 32'd13, 32'd1, 32'd17};
    for (int i = 0; i < 6; i++) begin
      do_run(l_tab[i], n_tab[i], ec, r, r2, e, b0);
      n_checks++;
      if (ec !== 2 || e !== 1'b1 || r !== 32'd0 || r2 !== 32'd0) begin
        n_fail++;
        $display("FAIL error_case%0d: got cycle=%0d err=%b r=%0d r2=%0d expected 2 1 0 0",
                 i, ec, e, r, r2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_end;
    int ends [2];
    logic [31:0] rs [2];
    logic [31:0] r2s [2];
    logic busy11;
    n_end = 0; ends = '{-1, -1}; busy11 = 1'b0;
    rs = '{32'd0, 32'd0}; r2s = '{32'd0, 32'd0};
    @(negedge clk);
    len = 8'd4; modulus = 32'd13; pc_start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk); #1;
      if (c == 11) busy11 = pc_busy;
      if (pc_end === 1'b1) begin
        if (n_end < 2) begin
          ends[n_end] = c; rs[n_end] = pc_r_mod; r2s[n_end] = pc_r2_mod;
        end
        n_end++;
      end
    end
    @(negedge clk); pc_start = 1'b0;
    n_checks++;
    if (n_end !== 2 || ends[0] !== 10 || ends[1] !== 21) begin
      n_fail++;
      $display("FAIL b2b_pulses: got count=%0d at %0d,%0d expected 2 at 10,21",
               n_end, ends[0], ends[1]);
    end
    n_checks++;
    if (busy11 !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept: got busy=%b expected 1", busy11); end
    n_checks++;
    if (rs[0] !== 32'd3 || r2s[0] !== 32'd9 || rs[1] !== 32'd3 || r2s[1] !== 32'd9) begin
      n_fail++;
      $display("FAIL b2b_result: got %0d/%0d and %0d/%0d expected 3/9 twice",
               rs[0], r2s[0], rs[1], r2s[1]);
    end
    // Drain any run still in progress before the next scenario.
    repeat (12) @(posedge clk);
  endtask

  task automatic test_mid_reset();
    int n_end;
    logic bad;
    int ec; logic [31:0] r, r2; logic e, b0;
    n_end = 0; bad = 1'b0;
    @(negedge clk);
    len = 8'd27; modulus = 32'd128255609; pc_start = 1'b1;
    @(posedge clk);
    @(negedge clk); pc_start = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({pc_r_mod, pc_r2_mod, pc_busy, pc_end, pc_err} !== 67'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got r=%h r2=%h busy=%b end=%b err=%b expected all 0",
               pc_r_mod, pc_r2_mod, pc_busy, pc_end, pc_err);
    end
    @(negedge clk); rstn = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (pc_end !== 1'b0) n_end++;
      if (pc_busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (n_end !== 0 || bad !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got %0d pc_end pulses, busy_seen=%b expected 0 0", n_end, bad);
    end
    do_run(8'd4, 32'd13, ec, r, r2, e, b0);
    n_checks++;
    if (ec !== 10 || r !== 32'd3 || r2 !== 32'd9 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_rerun: got cycle=%0d r=%0d r2=%0d err=%b expected 10 3 9 0", ec, r, r2, e);
    end
  endtask

  task automatic test_len32();
    int ec; logic [31:0] r, r2; logic e, b0;
    do_run(8'd32, 32'hFFFF_FFFB, ec, r, r2, e, b0);
    n_checks++;
    if (ec !== 66) begin n_fail++; $display("FAIL len32_latency: got %0d expected 66", ec); end
    n_checks++;
    if (r !== 32'd5 || r2 !== 32'd25 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL len32_result: got r=%0d r2=%0d err=%b expected 5 25 0", r, r2, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len27();
    test_errors();
    test_back_to_back();
    test_mid_reset();
    test_len32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
